// File: rtl/access_control.sv
// Access-control responder: collects a 4-digit ID and 4-digit password, checks them against a fixed user table.
// Optional lockout after repeated failures is built only when ACCESS_LOCKOUT_EN is defined.
module access_control #(
  parameter int NUM_USERS    = 4,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        enter,
  input  logic [3:0]  switches,
  output logic        access_control_fb,
  output logic [15:0] userid,
  output logic [2:0]  status,
  output logic [1:0]  digit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ID, S_GET_PW, S_CHECK, S_GRANTED, S_DENIED, S_LOCKED
  } state_e;

  // Entry i lives in bits [16*i +: 16].
  localparam logic [63:0] TBL_ID = {16'h0001, 16'hBEEF, 16'h0042, 16'h1234};
  localparam logic [63:0] TBL_PW = {16'h9999, 16'h1111, 16'h7777, 16'hAAAA};

  state_e      state_q, state_d;
  logic [15:0] id_q, id_d;
  logic [15:0] pw_q, pw_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] userid_q, userid_d;
  logic [2:0]  status_q, status_d;
  logic        fb_q, fb_d;
  logic        match;

`ifdef ACCESS_LOCKOUT_EN
  localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [ATT_W-1:0]  att_q, att_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
`endif

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < NUM_USERS && TBL_ID[16*i +: 16] == id_q && TBL_PW[16*i +: 16] == pw_q)
        match = 1'b1;
    end
  end

  function automatic logic [2:0] status_of(input state_e s);
    case (s)
      S_IDLE:             status_of = 3'd0;
      S_GET_ID:           status_of = 3'd1;
      S_GET_PW, S_CHECK:  status_of = 3'd2;
      S_GRANTED:          status_of = 3'd3;
      S_DENIED:           status_of = 3'd4;
      S_LOCKED:           status_of = 3'd5;
      default:            status_of = 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pw_d     = pw_q;
    cnt_d    = cnt_q;
    userid_d = userid_q;
`ifdef ACCESS_LOCKOUT_EN
    att_d    = att_q;
    lock_d   = lock_q;
`endif
    if (!enable) begin
      // Dropping enable discards the partial entry but keeps attempts and lock count.
      state_d = S_IDLE;
      id_d    = '0;
      pw_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          id_d  = '0;
          pw_d  = '0;
          cnt_d = '0;
`ifdef ACCESS_LOCKOUT_EN
          state_d = (lock_q != '0) ? S_LOCKED : S_GET_ID;
`else
          state_d = S_GET_ID;
`endif
        end
        S_GET_ID: begin
          if (enter) begin
            id_d  = {id_q[11:0], switches};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_GET_PW;
          end
        end
        S_GET_PW: begin
          if (enter) begin
            pw_d  = {pw_q[11:0], switches};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          id_d = '0;
          pw_d = '0;
          if (match) begin
            state_d  = S_GRANTED;
            userid_d = id_q;
`ifdef ACCESS_LOCKOUT_EN
            att_d    = '0;
`endif
          end else begin
`ifdef ACCESS_LOCKOUT_EN
            att_d = att_q + ATT_W'(1);
            if (att_d == ATT_W'(MAX_ATTEMPTS)) begin
              state_d = S_LOCKED;
              lock_d  = LOCK_W'(LOCK_CYCLES);
            end else begin
              state_d = S_DENIED;
            end
`else
            state_d = S_DENIED;
`endif
          end
        end
        S_GRANTED: state_d = S_GRANTED;
        S_DENIED: begin
          state_d = S_GET_ID;
          id_d    = '0;
          pw_d    = '0;
          cnt_d   = '0;
        end
        S_LOCKED: begin
`ifdef ACCESS_LOCKOUT_EN
          if (lock_q <= LOCK_W'(1)) begin
            lock_d  = '0;
            att_d   = '0;
            state_d = S_GET_ID;
            id_d    = '0;
            pw_d    = '0;
            cnt_d   = '0;
          end else begin
            lock_d = lock_q - LOCK_W'(1);
          end
`else
          state_d = S_GET_ID;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    status_d = status_of(state_d);
    fb_d     = (state_d == S_GRANTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      pw_q     <= '0;
      cnt_q    <= '0;
      userid_q <= '0;
      status_q <= '0;
      fb_q     <= 1'b0;
`ifdef ACCESS_LOCKOUT_EN
      att_q    <= '0;
      lock_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      userid_q <= userid_d;
      status_q <= status_d;
      fb_q     <= fb_d;
`ifdef ACCESS_LOCKOUT_EN
      att_q    <= att_d;
      lock_q   <= lock_d;
`endif
    end
  end

  assign access_control_fb = fb_q;
  assign userid            = userid_q;
  assign status            = status_q;
  assign digit_cnt         = cnt_q;

endmodule
